// File: rtl/adder_pipe_nbit_if.sv
// Streaming operand/result bundle for the pipelined add/subtract unit.
// master drives operands and result-ready; slave is the adder.
interface adder_pipe_nbit_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output ovf
  );
endinterface

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice resolved per stage.
// Pending operand slices shrink as the beat moves; resolved bits grow.
module adder_pipe_nbit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  adder_pipe_nbit_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic             valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign adv           = !valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int PW = WIDTH - k * CHUNK;
    localparam int RW = (k + 1) * CHUNK;

    logic           v_in;
    logic           sub_in;
    logic           c_in;
    logic [PW-1:0]  a_in;
    logic [PW-1:0]  b_in;
    logic [CHUNK:0] sl;
    logic [RW-1:0]  r_d;

    if (k == 0) begin : g_src
      assign v_in   = bus.in_valid;
      assign sub_in = bus.sub;
      assign c_in   = bus.sub ^ bus.cin;
      assign a_in   = bus.a;
      assign b_in   = bus.sub ? ~bus.b : bus.b;
      assign r_d    = sl[CHUNK-1:0];
    end else begin : g_src
      assign v_in   = g_st[k-1].g_reg.v_q;
      assign sub_in = g_st[k-1].g_reg.sub_q;
      assign c_in   = g_st[k-1].g_reg.c_q;
      assign a_in   = g_st[k-1].g_reg.a_q;
      assign b_in   = g_st[k-1].g_reg.b_q;
      assign r_d    = {sl[CHUNK-1:0],
                       g_st[k-1].g_reg.r_q};
    end

    assign sl = {1'b0, a_in[CHUNK-1:0]}
              + {1'b0, b_in[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, c_in};

    if (k < STAGES - 1) begin : g_reg
      logic             v_q;
      logic             sub_q;
      logic             c_q;
      logic [PW-CHUNK-1:0] a_q;
      logic [PW-CHUNK-1:0] b_q;
      logic [RW-1:0]    r_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          sub_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          r_q   <= '0;
        end else if (adv) begin
          v_q <= v_in;
          if (v_in) begin
            sub_q <= sub_in;
            c_q   <= sl[CHUNK];
            a_q   <= a_in[PW-1:CHUNK];
            b_q   <= b_in[PW-1:CHUNK];
            r_q   <= r_d;
          end
        end
      end
    end else begin : g_out
      // Overflow: equal operand signs whose result sign differs.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          sum_q   <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end else if (adv) begin
          valid_q <= v_in;
          if (v_in) begin
            sum_q  <= r_d;
            cout_q <= sub_in ^ sl[CHUNK];
            ovf_q  <= (a_in[CHUNK-1] == b_in[CHUNK-1])
                   && (sl[CHUNK-1] != a_in[CHUNK-1]);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: directed cases on a 32/8 pipe, then
// random streaming on 32/8, 8/8 and 24/4 against a signed/unsigned model.
module tb_adder_pipe_nbit;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  adder_pipe_nbit_if #(.WIDTH(32)) i0 ();
  adder_pipe_nbit_if #(.WIDTH(8))  i1 ();
  adder_pipe_nbit_if #(.WIDTH(24)) i2 ();

  adder_pipe_nbit #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(i0));
  adder_pipe_nbit #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1));
  adder_pipe_nbit #(.WIDTH(24), .CHUNK(4)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(i2));

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int total = 0;
  int bad   = 0;
  int got0  = 0;
  bit acc0, acc1, acc2;

  function automatic void model(input int w,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                input logic cin,
                                input logic sub,
                                output exp_t e);
    longint unsigned m, ua, ub, t;
    longint sa, sb, x, lim, ci;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    ci = cin ? 1 : 0;
    if (!sub) begin
      t    = ua + ub + longint'(ci);
      e.co = ((t >> w) & 64'd1) != 0;
    end else begin
      e.co = ua < (ub + longint'(ci));
      t    = ua - ub - longint'(ci);
    end
    e.s = 32'(t & m);
    sa  = longint'(ua);
    sb  = longint'(ub);
    if ((ua >> (w - 1)) != 0) sa = sa - longint'(64'd1 << w);
    if ((ub >> (w - 1)) != 0) sb = sb - longint'(64'd1 << w);
    x    = sub ? (sa - sb - ci) : (sa + sb + ci);
    lim  = longint'(64'd1 << (w - 1));
    e.ov = (x >= lim) || (x < -lim);
  endfunction

  function automatic logic [31:0] rop();
    case ($urandom_range(0, 7))
      0:       rop = 32'h0000_0000;
      1:       rop = 32'hFFFF_FFFF;
      2:       rop = 32'h8000_0000;
      3:       rop = 32'h7FFF_FFFF;
      default: rop = $urandom;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    #1;
    acc0 = i0.in_valid && i0.in_ready;
    acc1 = i1.in_valid && i1.in_ready;
    acc2 = i2.in_valid && i2.in_ready;
    if (i0.out_valid && i0.out_ready) begin
      chk("w32_pending", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("w32_sum", i0.sum, e.s);
        chk("w32_cout", 32'(i0.cout), 32'(e.co));
        chk("w32_ovf", 32'(i0.ovf), 32'(e.ov));
        got0++;
      end
    end
    if (i1.out_valid && i1.out_ready) begin
      chk("w8_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("w8_sum", 32'(i1.sum), e.s);
        chk("w8_cout", 32'(i1.cout), 32'(e.co));
        chk("w8_ovf", 32'(i1.ovf), 32'(e.ov));
      end
    end
    if (i2.out_valid && i2.out_ready) begin
      chk("w24_pending", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("w24_sum", 32'(i2.sum), e.s);
        chk("w24_cout", 32'(i2.cout), 32'(e.co));
        chk("w24_ovf", 32'(i2.ovf), 32'(e.ov));
      end
    end
    if (acc0) begin
      model(32, i0.a, i0.b, i0.cin, i0.sub, e);
      q0.push_back(e);
    end
    if (acc1) begin
      model(8, 32'(i1.a), 32'(i1.b), i1.cin, i1.sub, e);
      q1.push_back(e);
    end
    if (acc2) begin
      model(24, 32'(i2.a), 32'(i2.b), i2.cin, i2.sub, e);
      q2.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic one(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic cin,
                     input logic sub,
                     input logic [31:0] es,
                     input logic eco,
                     input logic eov);
    int lat;
    i0.a = a;
    i0.b = b;
    i0.cin = cin;
    i0.sub = sub;
    i0.in_valid = 1'b1;
    i0.out_ready = 1'b1;
    tick();
    chk({tag, "_acc"}, 32'(acc0), 32'd1);
    i0.in_valid = 1'b0;
    lat = 1;
    while (!i0.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd4);
    chk({tag, "_sum"}, i0.sum, es);
    chk({tag, "_cout"}, 32'(i0.cout), 32'(eco));
    chk({tag, "_ovf"}, 32'(i0.ovf), 32'(eov));
    tick();
  endtask

  initial begin
    int n, cyc, seen;
    logic [31:0] hs;
    logic hc, ho;
    rst_n = 1'b0;
    i0.in_valid = 1'b0; i0.out_ready = 1'b1;
    i0.a = '0; i0.b = '0; i0.cin = 1'b0; i0.sub = 1'b0;
    i1.in_valid = 1'b0; i1.out_ready = 1'b1;
    i1.a = '0; i1.b = '0; i1.cin = 1'b0; i1.sub = 1'b0;
    i2.in_valid = 1'b0; i2.out_ready = 1'b1;
    i2.a = '0; i2.b = '0; i2.cin = 1'b0; i2.sub = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_valid", 32'(i0.out_valid), 32'd0);
    chk("rst_sum", i0.sum, 32'd0);
    chk("rst_cout", 32'(i0.cout), 32'd0);
    chk("rst_ovf", 32'(i0.ovf), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(i0.in_ready), 32'd1);

    one("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
        32'h0000_0000, 1'b1, 1'b0);
    one("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
        32'h8000_0000, 1'b0, 1'b1);
    one("borrow", 32'h5, 32'h7, 1'b0, 1'b1,
        32'hFFFF_FFFE, 1'b1, 1'b0);
    one("subovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
        32'h7FFF_FFFF, 1'b0, 1'b1);
    one("cin", 32'h0000_00FF, 32'h0, 1'b1, 1'b0,
        32'h0000_0100, 1'b0, 1'b0);

    // Eight back-to-back beats with a three-cycle output stall.
    n = 0; cyc = 0; got0 = 0;
    hs = '0; hc = 1'b0; ho = 1'b0;
    i0.a = rop(); i0.b = rop();
    i0.cin = 1'($urandom); i0.sub = 1'($urandom);
    while (got0 < 8 && cyc < 60) begin
      i0.in_valid = (n < 8);
      i0.out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      if (cyc >= 5 && cyc <= 7) begin
        chk("stall_ready", 32'(i0.in_ready), 32'd0);
        chk("stall_valid", 32'(i0.out_valid), 32'd1);
      end
      if (cyc == 5) begin
        hs = i0.sum; hc = i0.cout; ho = i0.ovf;
      end
      if (cyc == 6 || cyc == 7) begin
        chk("hold_sum", i0.sum, hs);
        chk("hold_cout", 32'(i0.cout), 32'(hc));
        chk("hold_ovf", 32'(i0.ovf), 32'(ho));
      end
      tick();
      if (acc0) begin
        n++;
        i0.a = rop(); i0.b = rop();
        i0.cin = 1'($urandom); i0.sub = 1'($urandom);
      end
      cyc++;
    end
    chk("stream_sent", n, 32'd8);
    chk("stream_got", got0, 32'd8);
    chk("stream_left", q0.size(), 32'd0);

    // Reset with three beats in flight discards them.
    i0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i0.in_valid = 1'b1;
      i0.a = rop(); i0.b = rop();
      tick();
    end
    i0.in_valid = 1'b0;
    chk("flight_cnt", q0.size(), 32'd3);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(i0.out_valid), 32'd0);
    q0.delete();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i0.out_valid) seen++;
    end
    chk("midrst_ghost", seen, 32'd0);

    // Random streaming on all three geometries.
    for (int i = 0; i < 1000; i++) begin
      i0.in_valid = $urandom_range(0, 9) < 7;
      i0.out_ready = $urandom_range(0, 9) < 7;
      i0.a = rop(); i0.b = rop();
      i0.cin = 1'($urandom); i0.sub = 1'($urandom);
      i1.in_valid = $urandom_range(0, 9) < 7;
      i1.out_ready = $urandom_range(0, 9) < 7;
      i1.a = 8'(rop()); i1.b = 8'(rop());
      i1.cin = 1'($urandom); i1.sub = 1'($urandom);
      i2.in_valid = $urandom_range(0, 9) < 7;
      i2.out_ready = $urandom_range(0, 9) < 7;
      i2.a = 24'(rop()); i2.b = 24'(rop());
      i2.cin = 1'($urandom); i2.sub = 1'($urandom);
      tick();
    end
    i0.in_valid = 1'b0; i0.out_ready = 1'b1;
    i1.in_valid = 1'b0; i1.out_ready = 1'b1;
    i2.in_valid = 1'b0; i2.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("rand_w32_left", q0.size(), 32'd0);
    chk("rand_w8_left", q1.size(), 32'd0);
    chk("rand_w24_left", q2.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
